// File: rtl/wb_tlc_req_dec.sv
// Receive-side TLP request decoder: turns single-DW MRd32/MWr32 requests into one
// Wishbone master cycle and hands read data to the completion generator.
module wb_tlc_req_dec #(
  parameter int c_DATA_WIDTH = 64,
  parameter int c_WB_TIMEOUT = 255,
  parameter int c_CPL_GAP    = 3
) (
  input  logic                    wb_clk,
  input  logic                    rstn,
  input  logic [c_DATA_WIDTH-1:0] din,
  input  logic                    din_sop,
  input  logic                    din_eop,
  input  logic                    din_valid,
  output logic                    din_rdy,
  output logic [31:0]             wb_adr_o,
  output logic [c_DATA_WIDTH-1:0] wb_dat_o,
  output logic [7:0]              wb_sel_o,
  output logic                    wb_we_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  input  logic [c_DATA_WIDTH-1:0] wb_dat_i,
  output logic                    cpl_read,
  output logic                    cpl_valid,
  output logic [c_DATA_WIDTH-1:0] cpl_din,
  output logic [7:0]              cpl_sel,
  output logic [23:0]             tran_id,
  output logic [9:0]              tran_length,
  output logic [7:0]              tran_be,
  output logic [4:0]              tran_addr,
  output logic [2:0]              tran_tc,
  output logic [1:0]              tran_attr,
  output logic                    err_unsup,
  output logic                    err_malformed,
  output logic                    err_timeout
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR2    = 3'd1;
  localparam logic [2:0] ST_WB      = 3'd2;
  localparam logic [2:0] ST_CPL     = 3'd3;
  localparam logic [2:0] ST_DISCARD = 3'd4;

  localparam logic [7:0] TMO_LAST = 8'(c_WB_TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST = 8'(c_CPL_GAP - 1);

  logic [2:0]              state_q, state_d;
  logic                    din_rdy_q, din_rdy_d;
  logic [31:0]             adr_q, adr_d;
  logic [c_DATA_WIDTH-1:0] dat_q, dat_d;
  logic [7:0]              sel_q, sel_d;
  logic                    we_q, we_d;
  logic                    cyc_q, cyc_d;
  logic                    cpl_read_q, cpl_read_d;
  logic                    cpl_valid_q, cpl_valid_d;
  logic [c_DATA_WIDTH-1:0] cpl_din_q, cpl_din_d;
  logic [7:0]              cpl_sel_q, cpl_sel_d;
  logic [23:0]             tran_id_q, tran_id_d;
  logic [9:0]              tran_length_q, tran_length_d;
  logic [7:0]              tran_be_q, tran_be_d;
  logic [4:0]              tran_addr_q, tran_addr_d;
  logic [2:0]              tran_tc_q, tran_tc_d;
  logic [1:0]              tran_attr_q, tran_attr_d;
  logic                    err_unsup_q, err_unsup_d;
  logic                    err_mal_q, err_mal_d;
  logic                    err_tmo_q, err_tmo_d;
  logic                    is_rd_q, is_rd_d;
  logic [7:0]              cnt_q, cnt_d;

  logic       accept;
  logic [7:0] w0_type;
  logic [9:0] w0_length;
  logic       w0_supported;
  logic [3:0] lane_be;
  logic       unused_hdr_bits;

  assign accept       = din_valid & din_rdy_q;
  assign w0_type      = din[63:56];
  assign w0_length    = din[41:32];
  assign w0_supported = ((w0_type == 8'h00) || (w0_type == 8'h40)) &&
                        (w0_length == 10'd1) && !din[46];
  // A read with no enabled bytes still fetches the full DW.
  assign lane_be      = (is_rd_q && (tran_be_q[7:4] == 4'h0)) ? 4'hF : tran_be_q[7:4];
  assign unused_hdr_bits = ^{din[55], din[51:47], din[43:42]};

  always_comb begin
    state_d       = state_q;
    adr_d         = adr_q;
    dat_d         = dat_q;
    sel_d         = sel_q;
    we_d          = we_q;
    cyc_d         = cyc_q;
    cpl_din_d     = cpl_din_q;
    cpl_sel_d     = cpl_sel_q;
    tran_id_d     = tran_id_q;
    tran_length_d = tran_length_q;
    tran_be_d     = tran_be_q;
    tran_addr_d   = tran_addr_q;
    tran_tc_d     = tran_tc_q;
    tran_attr_d   = tran_attr_q;
    is_rd_d       = is_rd_q;
    cnt_d         = cnt_q;
    cpl_read_d    = 1'b0;
    cpl_valid_d   = 1'b0;
    err_unsup_d   = 1'b0;
    err_mal_d     = 1'b0;
    err_tmo_d     = 1'b0;
    case (state_q)
      // A sop seen while waiting for word1 restarts header decode on that word.
      ST_IDLE, ST_HDR2: begin
        if (accept && din_sop) begin
          if (state_q == ST_HDR2) err_mal_d = 1'b1;
          if (w0_supported) begin
            tran_id_d     = din[31:8];
            tran_length_d = w0_length;
            tran_be_d     = {din[3:0], din[7:4]};
            tran_tc_d     = din[54:52];
            tran_attr_d   = din[45:44];
            is_rd_d       = (w0_type == 8'h00);
            if (din_eop) begin
              err_mal_d = 1'b1;
              state_d   = ST_IDLE;
            end else begin
              state_d   = ST_HDR2;
            end
          end else begin
            err_unsup_d = 1'b1;
            state_d     = din_eop ? ST_IDLE : ST_DISCARD;
          end
        end else if (accept && (state_q == ST_HDR2)) begin
          if (!din_eop) begin
            err_mal_d = 1'b1;
            state_d   = ST_DISCARD;
          end else begin
            adr_d       = {din[63:35], 3'b000};
            dat_d       = {din[31:0], din[31:0]};
            sel_d       = din[34] ? {lane_be, 4'b0000} : {4'b0000, lane_be};
            we_d        = !is_rd_q;
            cyc_d       = 1'b1;
            tran_addr_d = din[38:34];
            cnt_d       = '0;
            cpl_read_d  = is_rd_q;
            state_d     = ST_WB;
          end
        end
      end
      ST_WB: begin
        if (wb_ack_i) begin
          cyc_d = 1'b0;
          cnt_d = '0;
          if (is_rd_q) begin
            cpl_din_d   = wb_dat_i;
            cpl_sel_d   = sel_q;
            cpl_valid_d = 1'b1;
            state_d     = ST_CPL;
          end else begin
            state_d     = ST_IDLE;
          end
        end else if (cnt_q == TMO_LAST) begin
          cyc_d     = 1'b0;
          cnt_d     = '0;
          err_tmo_d = 1'b1;
          if (is_rd_q) begin
            cpl_din_d   = '1;
            cpl_sel_d   = sel_q;
            cpl_valid_d = 1'b1;
            state_d     = ST_CPL;
          end else begin
            state_d     = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_CPL: begin
        if (cnt_q == GAP_LAST) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + 8'd1;
      end
      ST_DISCARD: begin
        if (accept && din_eop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    din_rdy_d = (state_d == ST_IDLE) || (state_d == ST_HDR2) || (state_d == ST_DISCARD);
  end

  always_ff @(posedge wb_clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      din_rdy_q     <= 1'b0;
      adr_q         <= '0;
      dat_q         <= '0;
      sel_q         <= '0;
      we_q          <= 1'b0;
      cyc_q         <= 1'b0;
      cpl_read_q    <= 1'b0;
      cpl_valid_q   <= 1'b0;
      cpl_din_q     <= '0;
      cpl_sel_q     <= '0;
      tran_id_q     <= '0;
      tran_length_q <= '0;
      tran_be_q     <= '0;
      tran_addr_q   <= '0;
      tran_tc_q     <= '0;
      tran_attr_q   <= '0;
      err_unsup_q   <= 1'b0;
      err_mal_q     <= 1'b0;
      err_tmo_q     <= 1'b0;
      is_rd_q       <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      din_rdy_q     <= din_rdy_d;
      adr_q         <= adr_d;
      dat_q         <= dat_d;
      sel_q         <= sel_d;
      we_q          <= we_d;
      cyc_q         <= cyc_d;
      cpl_read_q    <= cpl_read_d;
      cpl_valid_q   <= cpl_valid_d;
      cpl_din_q     <= cpl_din_d;
      cpl_sel_q     <= cpl_sel_d;
      tran_id_q     <= tran_id_d;
      tran_length_q <= tran_length_d;
      tran_be_q     <= tran_be_d;
      tran_addr_q   <= tran_addr_d;
      tran_tc_q     <= tran_tc_d;
      tran_attr_q   <= tran_attr_d;
      err_unsup_q   <= err_unsup_d;
      err_mal_q     <= err_mal_d;
      err_tmo_q     <= err_tmo_d;
      is_rd_q       <= is_rd_d;
      cnt_q         <= cnt_d;
    end
  end

  assign din_rdy       = din_rdy_q;
  assign wb_adr_o      = adr_q;
  assign wb_dat_o      = dat_q;
  assign wb_sel_o      = sel_q;
  assign wb_we_o       = we_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = cyc_q;
  assign cpl_read      = cpl_read_q;
  assign cpl_valid     = cpl_valid_q;
  assign cpl_din       = cpl_din_q;
  assign cpl_sel       = cpl_sel_q;
  assign tran_id       = tran_id_q;
  assign tran_length   = tran_length_q;
  assign tran_be       = tran_be_q;
  assign tran_addr     = tran_addr_q;
  assign tran_tc       = tran_tc_q;
  assign tran_attr     = tran_attr_q;
  assign err_unsup     = err_unsup_q;
  assign err_malformed = err_mal_q;
  assign err_timeout   = err_tmo_q;

endmodule

// File: tb/tb_wb_tlc_req_dec.sv
// Scoreboard bench for wb_tlc_req_dec: expected Wishbone cycles and completions are
// queued as TLPs are driven and popped when the DUT opens a cycle or pulses cpl_valid.
module tb_wb_tlc_req_dec;

  typedef struct {
    logic [31:0] adr;
    logic [7:0]  sel;
    logic        we;
    logic [63:0] dat;
  } wb_exp_t;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  sel;
  } cpl_exp_t;

  logic        wb_clk = 1'b0;
  logic        rstn = 1'b0;
  logic [63:0] din = '0;
  logic        din_sop = 1'b0, din_eop = 1'b0, din_valid = 1'b0;
  logic        din_rdy;
  logic [31:0] wb_adr_o;
  logic [63:0] wb_dat_o;
  logic [7:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic        wb_ack_i = 1'b0;
  logic [63:0] wb_dat_i = '0;
  logic        cpl_read, cpl_valid;
  logic [63:0] cpl_din;
  logic [7:0]  cpl_sel;
  logic [23:0] tran_id;
  logic [9:0]  tran_length;
  logic [7:0]  tran_be;
  logic [4:0]  tran_addr;
  logic [2:0]  tran_tc;
  logic [1:0]  tran_attr;
  logic        err_unsup, err_malformed, err_timeout;

  int checks = 0;
  int errors = 0;
  int n_unsup = 0, n_mal = 0, n_tmo = 0, n_rd = 0, n_cv = 0, n_wb = 0;
  wb_exp_t  wb_q[$];
  cpl_exp_t cpl_q[$];
  wb_exp_t  mon_w;
  cpl_exp_t mon_c;
  logic     cyc_prev = 1'b0;
  logic     all_zero;

  assign all_zero = ~|{din_rdy, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
                       cpl_read, cpl_valid, cpl_din, cpl_sel, tran_id, tran_length, tran_be,
                       tran_addr, tran_tc, tran_attr, err_unsup, err_malformed, err_timeout};

  always #5 wb_clk = ~wb_clk;

  wb_tlc_req_dec #(.c_DATA_WIDTH(64), .c_WB_TIMEOUT(255), .c_CPL_GAP(3)) dut (
    .wb_clk(wb_clk), .rstn(rstn),
    .din(din), .din_sop(din_sop), .din_eop(din_eop), .din_valid(din_valid), .din_rdy(din_rdy),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
    .cpl_read(cpl_read), .cpl_valid(cpl_valid), .cpl_din(cpl_din), .cpl_sel(cpl_sel),
    .tran_id(tran_id), .tran_length(tran_length), .tran_be(tran_be), .tran_addr(tran_addr),
    .tran_tc(tran_tc), .tran_attr(tran_attr),
    .err_unsup(err_unsup), .err_malformed(err_malformed), .err_timeout(err_timeout)
  );

  // Output monitor: pulse counters plus scoreboard pops, sampled just after each edge.
  always begin
    @(posedge wb_clk);
    #1;
    if (err_unsup)     n_unsup++;
    if (err_malformed) n_mal++;
    if (err_timeout)   n_tmo++;
    if (cpl_read)      n_rd++;
    checks++;
    if (wb_stb_o !== wb_cyc_o) begin
      errors++;
      $display("FAIL stb_eq_cyc got stb=%b cyc=%b want equal", wb_stb_o, wb_cyc_o);
    end
    if (wb_cyc_o && !cyc_prev) begin
      n_wb++;
      checks++;
      if (wb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got adr=%h sel=%h we=%b want no cycle", wb_adr_o, wb_sel_o, wb_we_o);
      end else begin
        mon_w = wb_q.pop_front();
        if ({wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o} !== {mon_w.adr, mon_w.sel, mon_w.we, mon_w.dat}) begin
          errors++;
          $display("FAIL wb_cycle got adr=%h sel=%h we=%b dat=%h want adr=%h sel=%h we=%b dat=%h",
                   wb_adr_o, wb_sel_o, wb_we_o, wb_dat_o, mon_w.adr, mon_w.sel, mon_w.we, mon_w.dat);
        end
      end
    end
    cyc_prev = wb_cyc_o;
    if (cpl_valid) begin
      n_cv++;
      checks++;
      if (cpl_q.size() == 0) begin
        errors++;
        $display("FAIL cpl_unexpected got din=%h sel=%h want no completion", cpl_din, cpl_sel);
      end else begin
        mon_c = cpl_q.pop_front();
        if ({cpl_din, cpl_sel} !== {mon_c.d, mon_c.sel}) begin
          errors++;
          $display("FAIL cpl_data got din=%h sel=%h want din=%h sel=%h", cpl_din, cpl_sel, mon_c.d, mon_c.sel);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish got timeout want finish");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge wb_clk);
  endtask

  // Presents one word from a negedge and returns on the negedge after it is taken.
  task automatic send_word(input logic [63:0] w, input logic s, input logic e, output bit ok);
    din = w; din_sop = s; din_eop = e; din_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = (din_rdy === 1'b1);
      @(negedge wb_clk);
    end
    din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    #12;
    checks++;
    if (all_zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs got nonzero outputs want all zero (din_rdy=%b cyc=%b)", din_rdy, wb_cyc_o);
    end
    @(negedge wb_clk);
    rstn = 1'b1;
    tick();
    checks++;
    if (din_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy got %b want 1", din_rdy);
    end
  endtask

  task automatic test_mrd;
    bit ok1, ok2;
    int rd0, cv0;
    rd0 = n_rd; cv0 = n_cv;
    wb_q.push_back('{adr: 32'h40, sel: 8'hF0, we: 1'b0, dat: 64'h0});
    cpl_q.push_back('{d: 64'hA5A5_A5A5_DEAD_BEEF, sel: 8'hF0});
    send_word(64'h0000_0001_1234_05F0, 1'b1, 1'b0, ok1);
    send_word({32'h0000_0044, 32'h0}, 1'b0, 1'b1, ok2);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL mrd_accept got %b%b want 11", ok1, ok2); end
    checks++;
    if (cpl_read !== 1'b1) begin errors++; $display("FAIL mrd_cpl_read got %b want 1", cpl_read); end
    checks++;
    if ({tran_id, tran_be, tran_addr, tran_length} !== {24'h123405, 8'h0F, 5'h11, 10'd1}) begin
      errors++;
      $display("FAIL mrd_tran got id=%h be=%h addr=%h len=%0d want id=123405 be=0f addr=11 len=1",
               tran_id, tran_be, tran_addr, tran_length);
    end
    checks++;
    if (wb_cyc_o !== 1'b1 || din_rdy !== 1'b0) begin
      errors++;
      $display("FAIL mrd_cycle_open got cyc=%b rdy=%b want cyc=1 rdy=0", wb_cyc_o, din_rdy);
    end
    wb_ack_i = 1'b1; wb_dat_i = 64'hA5A5_A5A5_DEAD_BEEF;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = '0;
    checks++;
    if (cpl_valid !== 1'b1 || wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL mrd_cpl_valid got valid=%b cyc=%b want valid=1 cyc=0", cpl_valid, wb_cyc_o);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (din_rdy !== (i == 3)) begin
        errors++;
        $display("FAIL mrd_gap cycle %0d got rdy=%b want %b", i, din_rdy, (i == 3));
      end
      if (i < 3) tick();
    end
    checks++;
    if (n_rd - rd0 != 1 || n_cv - cv0 != 1) begin
      errors++;
      $display("FAIL mrd_pulses got read=%0d valid=%0d want 1 1", n_rd - rd0, n_cv - cv0);
    end
  endtask

  task automatic test_mwr;
    bit ok1, ok2;
    int rd0, cv0;
    rd0 = n_rd; cv0 = n_cv;
    wb_q.push_back('{adr: 32'h8, sel: 8'h03, we: 1'b1, dat: 64'hCAFEF00D_CAFEF00D});
    send_word(64'h4000_0001_0000_0003, 1'b1, 1'b0, ok1);
    send_word({32'h0000_0008, 32'hCAFEF00D}, 1'b0, 1'b1, ok2);
    checks++;
    if (!(ok1 && ok2) || wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL mwr_open got ok=%b%b cyc=%b want 11 cyc=1", ok1, ok2, wb_cyc_o);
    end
    tick(2);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    checks++;
    if (din_rdy !== 1'b1 || wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL mwr_done got rdy=%b cyc=%b want rdy=1 cyc=0", din_rdy, wb_cyc_o);
    end
    tick(3);
    checks++;
    if (n_rd != rd0 || n_cv != cv0) begin
      errors++;
      $display("FAIL mwr_no_cpl got read=%0d valid=%0d want 0 0", n_rd - rd0, n_cv - cv0);
    end
  endtask

  task automatic test_timeout;
    bit ok1, ok2;
    int t0, cnt;
    t0 = n_tmo; cnt = 0;
    wb_q.push_back('{adr: 32'h10, sel: 8'h0F, we: 1'b0, dat: 64'h0});
    cpl_q.push_back('{d: 64'hFFFF_FFFF_FFFF_FFFF, sel: 8'h0F});
    send_word(64'h0050_A001_ABCD_7700, 1'b1, 1'b0, ok1);
    send_word({32'h0000_0010, 32'h0}, 1'b0, 1'b1, ok2);
    checks++;
    if (!(ok1 && ok2) || {tran_id, tran_be, tran_addr, tran_tc, tran_attr} !== {24'hABCD77, 8'h00, 5'h04, 3'd5, 2'd2}) begin
      errors++;
      $display("FAIL tmo_tran got ok=%b%b id=%h be=%h addr=%h tc=%0d attr=%0d want 11 abcd77 00 04 5 2",
               ok1, ok2, tran_id, tran_be, tran_addr, tran_tc, tran_attr);
    end
    for (int i = 0; i < 400; i++) begin
      if (wb_cyc_o !== 1'b1) break;
      cnt++;
      tick();
    end
    checks++;
    if (cnt != 255) begin errors++; $display("FAIL tmo_cycles got %0d want 255", cnt); end
    checks++;
    if (err_timeout !== 1'b1 || cpl_valid !== 1'b1) begin
      errors++;
      $display("FAIL tmo_pulse got tmo=%b valid=%b want 1 1", err_timeout, cpl_valid);
    end
    tick(4);
    checks++;
    if (n_tmo - t0 != 1 || din_rdy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_count got pulses=%0d rdy=%b want 1 1", n_tmo - t0, din_rdy);
    end
  endtask

  task automatic test_ack_at_timeout;
    bit ok1, ok2;
    int t0;
    t0 = n_tmo;
    wb_q.push_back('{adr: 32'h20, sel: 8'hF0, we: 1'b0, dat: 64'h0});
    cpl_q.push_back('{d: 64'h0123_4567_89AB_CDEF, sel: 8'hF0});
    send_word(64'h0000_0001_0102_030F, 1'b1, 1'b0, ok1);
    send_word({32'h0000_0024, 32'h0}, 1'b0, 1'b1, ok2);
    tick(254);
    checks++;
    if (!(ok1 && ok2) || wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL late_ack_open got ok=%b%b cyc=%b want 11 cyc=1", ok1, ok2, wb_cyc_o);
    end
    wb_ack_i = 1'b1; wb_dat_i = 64'h0123_4567_89AB_CDEF;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = '0;
    checks++;
    if (cpl_valid !== 1'b1 || err_timeout !== 1'b0 || wb_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL late_ack got valid=%b tmo=%b cyc=%b want 1 0 0", cpl_valid, err_timeout, wb_cyc_o);
    end
    tick(4);
    checks++;
    if (n_tmo != t0) begin errors++; $display("FAIL late_ack_tmo got %0d want 0", n_tmo - t0); end
  endtask

  task automatic test_unsup;
    bit ok, all_ok;
    int u0, m0, w0;
    u0 = n_unsup; m0 = n_mal; w0 = n_wb; all_ok = 1'b1;
    send_word(64'h2000_0001_0000_000F, 1'b1, 1'b0, ok); all_ok &= ok;
    checks++;
    if (err_unsup !== 1'b1) begin errors++; $display("FAIL unsup_pulse got %b want 1", err_unsup); end
    send_word(64'h1111, 1'b0, 1'b0, ok); all_ok &= ok;
    send_word(64'h2222, 1'b1, 1'b0, ok); all_ok &= ok;
    send_word(64'h3333, 1'b0, 1'b1, ok); all_ok &= ok;
    send_word(64'h4000_0002_0000_000F, 1'b1, 1'b0, ok); all_ok &= ok;
    send_word(64'h5555, 1'b0, 1'b0, ok); all_ok &= ok;
    send_word(64'h6666, 1'b0, 1'b1, ok); all_ok &= ok;
    send_word(64'h0000_4001_0000_000F, 1'b1, 1'b1, ok); all_ok &= ok;
    checks++;
    if (!all_ok || din_rdy !== 1'b1) begin
      errors++;
      $display("FAIL unsup_drain got accepted=%b rdy=%b want 1 1", all_ok, din_rdy);
    end
    tick();
    checks++;
    if (n_unsup - u0 != 3 || n_mal != m0 || n_wb != w0) begin
      errors++;
      $display("FAIL unsup_count got unsup=%0d mal=%0d wb=%0d want 3 0 0", n_unsup - u0, n_mal - m0, n_wb - w0);
    end
  endtask

  task automatic test_malformed;
    bit ok, all_ok;
    int u0, m0, w0;
    u0 = n_unsup; m0 = n_mal; w0 = n_wb; all_ok = 1'b1;
    send_word(64'h1234, 1'b0, 1'b1, ok); all_ok &= ok;
    send_word(64'h4000_0001_0000_000F, 1'b1, 1'b0, ok); all_ok &= ok;
    send_word({32'h0000_0008, 32'h1}, 1'b0, 1'b0, ok); all_ok &= ok;
    checks++;
    if (err_malformed !== 1'b1) begin errors++; $display("FAIL mal_word1 got %b want 1", err_malformed); end
    send_word(64'h0, 1'b0, 1'b1, ok); all_ok &= ok;
    send_word(64'h4000_0001_0000_000F, 1'b1, 1'b1, ok); all_ok &= ok;
    checks++;
    if (err_malformed !== 1'b1) begin errors++; $display("FAIL mal_short got %b want 1", err_malformed); end
    tick();
    checks++;
    if (!all_ok || din_rdy !== 1'b1 || n_mal - m0 != 2 || n_unsup != u0 || n_wb != w0) begin
      errors++;
      $display("FAIL mal_count got ok=%b rdy=%b mal=%0d unsup=%0d wb=%0d want 1 1 2 0 0",
               all_ok, din_rdy, n_mal - m0, n_unsup - u0, n_wb - w0);
    end
  endtask

  task automatic test_reset_mid_cycle;
    bit ok1, ok2;
    wb_q.push_back('{adr: 32'h40, sel: 8'hF0, we: 1'b0, dat: 64'h0});
    send_word(64'h0000_0001_1234_05F0, 1'b1, 1'b0, ok1);
    send_word({32'h0000_0044, 32'h0}, 1'b0, 1'b1, ok2);
    tick();
    checks++;
    if (!(ok1 && ok2) || wb_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_open got ok=%b%b cyc=%b want 11 cyc=1", ok1, ok2, wb_cyc_o);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (all_zero !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_outputs got cyc=%b stb=%b rdy=%b want all outputs zero", wb_cyc_o, wb_stb_o, din_rdy);
    end
    @(negedge wb_clk);
    rstn = 1'b1;
    tick();
    checks++;
    if (din_rdy !== 1'b1) begin errors++; $display("FAIL rst_mid_rdy got %b want 1", din_rdy); end
    test_mrd();
  endtask

  initial begin
    test_reset();
    test_mrd();
    test_mwr();
    test_timeout();
    test_ack_at_timeout();
    test_unsup();
    test_malformed();
    test_reset_mid_cycle();
    tick(2);
    checks++;
    if (wb_q.size() != 0 || cpl_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got wb=%0d cpl=%0d want 0 0", wb_q.size(), cpl_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
